bfs_dc_resp: RTL and testbench

BFS_DC_RESP -- requirements
Module: bfs_dc_resp

---
 rtl/bfs_dc_resp.sv | 198 +++++++++++++++++++
 tb/tb_bfs_dc_resp.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bfs_dc_resp.sv
// BFS node-fetch responder: queues node addresses, reads each header, marks unvisited
// nodes, fetches their neighbor beats and streams whole frames back to the core.
module bfs_dc_resp #(
  parameter int RQ_DEPTH = 4,
  parameter int RB_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bfs_dc_req,
  input  logic [31:0] bfs_dc_addr,
  output logic        dc_ready,
  output logic        dc_rbuf_empty,
  output logic        dc_rvalid,
  output logic        dc_fs,
  output logic [63:0] dc_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  input  logic        rob_flush
);
  localparam int QW = (RQ_DEPTH > 1) ? $clog2(RQ_DEPTH) : 1;
  localparam int QC = $clog2(RQ_DEPTH + 1);
  localparam int BW = $clog2(RB_DEPTH);
  localparam int BC = $clog2(RB_DEPTH + 1);
  localparam logic [BC-1:0] OCC_MAX = BC'(RB_DEPTH - 9);

  typedef enum logic [2:0] {IDLE, HDR_RD, HDR_WAIT, MARK_WR, NB_RD, NB_WAIT, DRAIN} state_t;

  state_t        state_q;
  logic [31:0]   a_q;
  logic [3:0]    nb_left_q;
  logic          mem_req_q, mem_we_q;
  logic [31:0]   mem_addr_q;
  logic [63:0]   mem_wdata_q;

  logic [31:0]   rq_mem [RQ_DEPTH];
  logic [QW-1:0] rq_wp_q, rq_rp_q;
  logic [QC-1:0] rq_cnt_q;

  // Each entry holds {first-beat flag, data}.
  logic [64:0]   rb_mem [RB_DEPTH];
  logic [BW-1:0] rb_wp_q, rb_rp_q;
  logic [BC-1:0] cmt_cnt_q, stg_cnt_q, occ;
  logic          rvalid_q, fs_q;
  logic [63:0]   rdata_q;

  logic rq_push, start, need_mark, waiting, stage_we, commit, out_pop, rd_acc;
  logic [3:0] nb_total;

  function automatic logic [QW-1:0] q_inc(input logic [QW-1:0] p);
    return (p == QW'(RQ_DEPTH - 1)) ? '0 : p + QW'(1);
  endfunction

  function automatic logic [BW-1:0] b_inc(input logic [BW-1:0] p);
    return (p == BW'(RB_DEPTH - 1)) ? '0 : p + BW'(1);
  endfunction

  assign occ       = cmt_cnt_q + stg_cnt_q;
  assign dc_ready  = (rq_cnt_q != QC'(RQ_DEPTH)) && !rob_flush;
  assign rq_push   = bfs_dc_req && dc_ready;
  // A node is only started when its largest possible frame (9 beats) is guaranteed room.
  assign start     = (state_q == IDLE) && (rq_cnt_q != '0) && (occ <= OCC_MAX) && !rob_flush;
  assign need_mark = !mem_rdata[0] && (mem_rdata[35:32] != 4'd0);
  assign nb_total  = 4'(({1'b0, mem_rdata[35:32]} + 5'd1) >> 1);
  assign waiting   = (state_q == HDR_WAIT) || (state_q == NB_WAIT) || (state_q == DRAIN);
  assign stage_we  = !rob_flush && mem_rvalid && ((state_q == HDR_WAIT) || (state_q == NB_WAIT));
  assign commit    = stage_we && ((state_q == HDR_WAIT) ? !need_mark : (nb_left_q == 4'd1));
  assign out_pop   = !rob_flush && (cmt_cnt_q != '0);
  assign rd_acc    = mem_req_q && mem_ready && !mem_we_q;

  assign dc_rbuf_empty = (rq_cnt_q == '0) && (state_q == IDLE) && (occ == '0);
  assign dc_rvalid = rvalid_q;
  assign dc_fs     = fs_q;
  assign dc_rdata  = rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  always_ff @(posedge clk) begin
    if (rq_push) rq_mem[rq_wp_q] <= bfs_dc_addr;
    if (stage_we) rb_mem[rb_wp_q] <= {state_q == HDR_WAIT, mem_rdata};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rq_wp_q  <= '0;
      rq_rp_q  <= '0;
      rq_cnt_q <= '0;
    end else if (rob_flush) begin
      rq_wp_q  <= '0;
      rq_rp_q  <= '0;
      rq_cnt_q <= '0;
    end else begin
      if (rq_push) rq_wp_q <= q_inc(rq_wp_q);
      if (start)   rq_rp_q <= q_inc(rq_rp_q);
      rq_cnt_q <= rq_cnt_q + QC'(rq_push) - QC'(start);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      nb_left_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else if (rob_flush) begin
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      // A read accepted now, or one still in flight, must have its response swallowed.
      state_q   <= (rd_acc || (waiting && !mem_rvalid)) ? DRAIN : IDLE;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          a_q        <= rq_mem[rq_rp_q];
          mem_addr_q <= rq_mem[rq_rp_q];
          mem_req_q  <= 1'b1;
          mem_we_q   <= 1'b0;
          state_q    <= HDR_RD;
        end
        HDR_RD: if (mem_ready) begin
          mem_req_q <= 1'b0;
          state_q   <= HDR_WAIT;
        end
        HDR_WAIT: if (mem_rvalid) begin
          if (need_mark) begin
            nb_left_q   <= nb_total;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= a_q;
            mem_wdata_q <= mem_rdata | 64'd1;
            state_q     <= MARK_WR;
          end else begin
            state_q <= IDLE;
          end
        end
        MARK_WR: if (mem_ready) begin
          mem_we_q   <= 1'b0;
          mem_addr_q <= a_q + 32'd8;
          state_q    <= NB_RD;
        end
        NB_RD: if (mem_ready) begin
          mem_req_q <= 1'b0;
          state_q   <= NB_WAIT;
        end
        NB_WAIT: if (mem_rvalid) begin
          if (nb_left_q == 4'd1) begin
            state_q <= IDLE;
          end else begin
            nb_left_q  <= nb_left_q - 4'd1;
            mem_addr_q <= mem_addr_q + 32'd8;
            mem_req_q  <= 1'b1;
            state_q    <= NB_RD;
          end
        end
        DRAIN: if (mem_rvalid) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_wp_q   <= '0;
      rb_rp_q   <= '0;
      cmt_cnt_q <= '0;
      stg_cnt_q <= '0;
      rvalid_q  <= 1'b0;
      fs_q      <= 1'b0;
      rdata_q   <= '0;
    end else if (rob_flush) begin
      rb_wp_q   <= '0;
      rb_rp_q   <= '0;
      cmt_cnt_q <= '0;
      stg_cnt_q <= '0;
      rvalid_q  <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      if (stage_we) rb_wp_q <= b_inc(rb_wp_q);
      if (out_pop) begin
        {fs_q, rdata_q} <= rb_mem[rb_rp_q];
        rb_rp_q         <= b_inc(rb_rp_q);
      end else begin
        fs_q <= 1'b0;
      end
      rvalid_q  <= out_pop;
      cmt_cnt_q <= cmt_cnt_q - BC'(out_pop) + (commit ? stg_cnt_q + BC'(1) : '0);
      stg_cnt_q <= commit ? '0 : stg_cnt_q + BC'(stage_we);
    end
  end
endmodule

// File: tb/tb_bfs_dc_resp.sv
// Scoreboard bench for bfs_dc_resp: a node-level reference model predicts memory
// accesses and output frames; responder and beat monitor check them independently.
module tb_bfs_dc_resp;
  localparam int RB = 16;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        bfs_dc_req = 1'b0, mem_ready = 1'b0, mem_rvalid = 1'b0, rob_flush = 1'b0;
  logic [31:0] bfs_dc_addr = '0;
  logic [63:0] mem_rdata = '0;
  logic        dc_ready, dc_rbuf_empty, dc_rvalid, dc_fs, mem_req, mem_we;
  logic [63:0] dc_rdata, mem_wdata;
  logic [31:0] mem_addr;

  bfs_dc_resp #(.RQ_DEPTH(4), .RB_DEPTH(RB)) dut (
    .clk(clk), .rst_n(rst_n), .bfs_dc_req(bfs_dc_req), .bfs_dc_addr(bfs_dc_addr),
    .dc_ready(dc_ready), .dc_rbuf_empty(dc_rbuf_empty), .dc_rvalid(dc_rvalid),
    .dc_fs(dc_fs), .dc_rdata(dc_rdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .rob_flush(rob_flush));

  always #5 clk = ~clk;

  typedef struct { logic we; logic [31:0] addr; logic [63:0] wdata; bit hdr; int len; } acc_t;
  typedef struct { logic fs; logic [63:0] d; bit last; } beat_t;
  typedef struct { logic [63:0] d; int due; } pend_t;

  acc_t  exp_acc[$];
  beat_t exp_beats[$];
  pend_t pend[$];
  logic [63:0] ref_mem [logic [31:0]];
  logic [63:0] sim_mem [logic [31:0]];

  int n_pass = 0, n_chk = 0;
  int mode = 1, lat_min = 1, lat_max = 1, cyc = 0;
  int started_total = 0, beats_out = 0;
  logic [31:0] watch_addr = 32'hFFFF_FFFF;
  bit watch_hit = 0;
  bit in_frame = 0;
  logic [31:0] pool [13];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp_v);
  endtask

  function automatic logic [63:0] rmem(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 64'd0;
  endfunction

  task automatic set_word(input logic [31:0] a, input logic [63:0] d);
    ref_mem[a] = d;
    sim_mem[a] = d;
  endtask

  task automatic mk_node(input logic [31:0] a, input int n, input bit mark);
    logic [63:0] h;
    h = {$urandom, $urandom};
    h[35:32] = 4'(n);
    h[0] = mark;
    set_word(a, h);
    for (int k = 1; k <= 8; k++) set_word(a + 32'(8 * k), {$urandom, $urandom});
  endtask

  // Node-level reference: what a request for address a must produce.
  task automatic model_push(input logic [31:0] a);
    logic [63:0] h;
    logic [31:0] ad;
    int n, len;
    h = rmem(a);
    n = int'(h[35:32]);
    len = (!h[0] && n != 0) ? 1 + (n + 1) / 2 : 1;
    exp_acc.push_back('{we: 1'b0, addr: a, wdata: 64'd0, hdr: 1'b1, len: len});
    exp_beats.push_back('{fs: 1'b1, d: h, last: (len == 1)});
    if (len > 1) begin
      exp_acc.push_back('{we: 1'b1, addr: a, wdata: h | 64'd1, hdr: 1'b0, len: 0});
      ref_mem[a] = h | 64'd1;
      for (int k = 1; k < len; k++) begin
        ad = a + 32'(8 * k);
        exp_acc.push_back('{we: 1'b0, addr: ad, wdata: 64'd0, hdr: 1'b0, len: 0});
        exp_beats.push_back('{fs: 1'b0, d: rmem(ad), last: (k == len - 1)});
      end
    end
  endtask

  // Memory responder: random ready, in-order reads with latency >= 1.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      pend.delete();
      mem_ready = 1'b0;
      mem_rvalid = 1'b0;
    end else begin
      cyc++;
      mem_ready = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (mem_req && mem_ready) begin
        if (exp_acc.size() == 0) begin
          chk("unexpected_access", {mem_we, mem_addr}, 33'd0);
        end else begin
          acc_t e;
          e = exp_acc.pop_front();
          chk("access", {mem_we, mem_addr}, {e.we, e.addr});
          if (e.we) chk("mark_wdata", mem_wdata, e.wdata);
          if (e.hdr) begin
            chk("rb_room_at_start", 1'((started_total - beats_out) <= RB - 9), 1'b1);
            started_total += e.len;
          end
        end
        if (mem_we) sim_mem[mem_addr] = mem_wdata;
        else begin
          pend.push_back('{d: sim_mem.exists(mem_addr) ? sim_mem[mem_addr] : 64'd0,
                           due: cyc + $urandom_range(lat_min, lat_max)});
          if (mem_addr == watch_addr) watch_hit = 1;
        end
      end
      mem_rvalid = 1'b0;
      if (pend.size() != 0 && pend[0].due <= cyc) begin
        mem_rvalid = 1'b1;
        mem_rdata = pend[0].d;
        void'(pend.pop_front());
      end
    end
  end

  // Output monitor: every beat against the scoreboard, no gaps inside a frame.
  initial forever begin
    @(negedge clk);
    if (!rst_n) in_frame = 0;
    else begin
      if (in_frame && !dc_rvalid) begin
        chk("frame_bubble", dc_rvalid, 1'b1);
        in_frame = 0;
      end
      if (dc_rvalid) begin
        beats_out++;
        if (exp_beats.size() == 0) chk("unexpected_beat", {dc_fs, dc_rdata}, 65'd0);
        else begin
          beat_t e;
          e = exp_beats.pop_front();
          chk("beat", {dc_fs, dc_rdata}, {e.fs, e.d});
          in_frame = !e.last;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a);
    int n;
    n = 0;
    bfs_dc_req = 1'b1;
    bfs_dc_addr = a;
    while (!dc_ready && n < 500) begin step(); n++; end
    chk("send_accepted", 1'(n < 500), 1'b1);
    if (n < 500) model_push(a);
    step();
    bfs_dc_req = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(exp_beats.size() == 0 && exp_acc.size() == 0 && dc_rbuf_empty && !dc_rvalid)
           && n < 3000) begin step(); n++; end
    chk("idle_reached", 1'(n < 3000), 1'b1);
  endtask

  task automatic check_reset_vals();
    chk("rst_ctrl", {dc_ready, dc_rbuf_empty, dc_rvalid, dc_fs, mem_req, mem_we}, 6'b110000);
    chk("rst_data", {dc_rdata, mem_addr}, 96'd0);
    chk("rst_wdata", mem_wdata, 64'd0);
  endtask

  task automatic clear_sb();
    exp_acc.delete();
    exp_beats.delete();
    started_total = 0;
    beats_out = 0;
  endtask

  initial begin
    logic [31:0] lst [5];
    int acc_n, n;
    #12;
    check_reset_vals();
    step();
    rst_n = 1'b1;
    step();

    // Unvisited node with 3 neighbors, then an already visited one.
    set_word(32'h100, 64'h0000_0003_0000_0000);
    set_word(32'h108, {$urandom, $urandom});
    set_word(32'h110, {$urandom, $urandom});
    set_word(32'h200, 64'h0000_0005_0000_0001);
    for (int i = 0; i < 12; i++)
      mk_node(32'h1000 + 32'(i * 256), $urandom_range(0, 15), ($urandom_range(0, 3) == 0));
    for (int i = 0; i < 12; i++) pool[i] = 32'h1000 + 32'(i * 256);
    pool[12] = 32'hFFFF_FFF8;
    mk_node(32'hFFFF_FFF8, 4, 1'b0);
    send(32'h100);
    wait_idle();
    chk("marked_in_mem", sim_mem[32'h100], 64'h0000_0003_0000_0001);
    send(32'h200);
    wait_idle();

    // Request FIFO backpressure with memory stalled.
    mode = 2;
    send(pool[0]);
    for (int i = 0; i < 5; i++) lst[i] = pool[i + 1];
    acc_n = 0;
    for (int i = 0; i < 5; i++) begin
      bfs_dc_req = 1'b1;
      bfs_dc_addr = lst[acc_n];
      if (dc_ready) begin model_push(lst[acc_n]); acc_n++; end
      step();
    end
    chk("fifo_accepts", acc_n, 4);
    chk("fifo_full_ready", dc_ready, 1'b0);
    chk("busy_not_empty", dc_rbuf_empty, 1'b0);
    mode = 0;
    lat_min = 1; lat_max = 3;
    send(lst[4]);
    wait_idle();

    // Maximum-size frames back to back across buffer wrap.
    mode = 1; lat_min = 1; lat_max = 1;
    for (int i = 0; i < 6; i++) mk_node(32'h2000 + 32'(i * 256), 15, 1'b0);
    for (int i = 0; i < 6; i++) send(32'h2000 + 32'(i * 256));
    wait_idle();

    // Randomized traffic over the node pool (repeats hit the visited path).
    mode = 0; lat_min = 1; lat_max = 3;
    for (int i = 0; i < 40; i++) begin
      send(pool[$urandom_range(0, 12)]);
      n = $urandom_range(0, 3);
      for (int j = 0; j < n; j++) step();
    end
    wait_idle();

    // Flush while a neighbor read is outstanding.
    mode = 1; lat_min = 6; lat_max = 6;
    mk_node(32'h300, 4, 1'b0);
    watch_addr = 32'h308; watch_hit = 0;
    send(32'h300);
    n = 0;
    while (!watch_hit && n < 200) begin step(); n++; end
    chk("nb_read_seen", watch_hit, 1'b1);
    step();
    rob_flush = 1'b1;
    clear_sb();
    #1;
    chk("flush_ready_low", dc_ready, 1'b0);
    step();
    rob_flush = 1'b0;
    chk("flush_no_rvalid", dc_rvalid, 1'b0);
    chk("drain_not_empty", dc_rbuf_empty, 1'b0);
    n = 0;
    while (!mem_rvalid && n < 50) begin step(); n++; end
    chk("late_resp_seen", mem_rvalid, 1'b1);
    step();
    chk("empty_after_drain", dc_rbuf_empty, 1'b1);
    lat_min = 1; lat_max = 2;
    mk_node(32'h3000, 3, 1'b0);
    send(32'h3000);
    wait_idle();

    // Asynchronous reset in the middle of a frame.
    mk_node(32'h400, 6, 1'b0);
    watch_addr = 32'h408; watch_hit = 0;
    send(32'h400);
    n = 0;
    while (!watch_hit && n < 200) begin step(); n++; end
    chk("nb_read_seen2", watch_hit, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    clear_sb();
    step();
    rst_n = 1'b1;
    step();
    mk_node(32'h500, 2, 1'b0);
    send(32'h500);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
